// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and datapath signal bundle for alu_arbiter.
// master = requesters + datapath side, slave = the arbiter itself.
interface alu_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic [ADDRESS_WIDTH-1:0] req0_rs1;
    logic [ADDRESS_WIDTH-1:0] req0_rs2;
    logic [ADDRESS_WIDTH-1:0] req0_rd;
    logic [DATA_WIDTH-1:0]    req0_imm;
    logic                     req0_alusrc;
    logic                     req0_aluctrl;
    logic                     req0_wr;

    logic                     req1_valid;
    logic                     req1_ready;
    logic [ADDRESS_WIDTH-1:0] req1_rs1;
    logic [ADDRESS_WIDTH-1:0] req1_rs2;
    logic [ADDRESS_WIDTH-1:0] req1_rd;
    logic [DATA_WIDTH-1:0]    req1_imm;
    logic                     req1_alusrc;
    logic                     req1_aluctrl;
    logic                     req1_wr;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_id;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic                     rsp_eq;

    logic [ADDRESS_WIDTH-1:0] dp_rs1;
    logic [ADDRESS_WIDTH-1:0] dp_rs2;
    logic [ADDRESS_WIDTH-1:0] dp_rd;
    logic [DATA_WIDTH-1:0]    dp_imm;
    logic                     dp_alusrc;
    logic                     dp_aluctrl;
    logic                     dp_regwrite;
    logic [DATA_WIDTH-1:0]    dp_aluout;
    logic                     dp_eq;

    logic                     busy;

    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_rd, req0_imm,
               req0_alusrc, req0_aluctrl, req0_wr,
        input  req0_ready,
        output req1_valid, req1_rs1, req1_rs2, req1_rd, req1_imm,
               req1_alusrc, req1_aluctrl, req1_wr,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_eq,
        output rsp_ready,
        input  dp_rs1, dp_rs2, dp_rd, dp_imm, dp_alusrc, dp_aluctrl, dp_regwrite,
        output dp_aluout, dp_eq,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_rd, req0_imm,
               req0_alusrc, req0_aluctrl, req0_wr,
        output req0_ready,
        input  req1_valid, req1_rs1, req1_rs2, req1_rd, req1_imm,
               req1_alusrc, req1_aluctrl, req1_wr,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_eq,
        input  rsp_ready,
        output dp_rs1, dp_rs2, dp_rd, dp_imm, dp_alusrc, dp_aluctrl, dp_regwrite,
        input  dp_aluout, dp_eq,
        output busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter/sequencer for the shared
// regfile + ALU datapath. One op at a time: IDLE -> EXEC -> COMMIT -> RESP.
// Optional macro X0_GUARD_EN suppresses write-back to register 0.
module alu_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RESP} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    imm;
        logic                     alusrc;
        logic                     aluctrl;
        logic                     wr;
    } cmd_t;

    state_t                state;
    state_t                state_next;
    cmd_t                  req0_cmd;
    cmd_t                  req1_cmd;
    cmd_t                  cmd_q;
    logic                  gnt0;
    logic                  gnt1;
    logic                  gnt_id_q;
    logic                  last_q;
    logic                  rsp_id_q;
    logic                  rsp_eq_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    assign req0_cmd = {bus.req0_rs1, bus.req0_rs2, bus.req0_rd, bus.req0_imm,
                       bus.req0_alusrc, bus.req0_aluctrl, bus.req0_wr};
    assign req1_cmd = {bus.req1_rs1, bus.req1_rs2, bus.req1_rd, bus.req1_imm,
                       bus.req1_alusrc, bus.req1_aluctrl, bus.req1_wr};

    // Grant only in IDLE; on a tie the requester not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    // Next-state sequencing: fixed three-cycle run, then wait on the consumer.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (gnt0 || gnt1) state_next = EXEC;
            EXEC:    state_next = COMMIT;
            COMMIT:  state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Command latch on grant; response capture and priority update at COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= '0;
            gnt_id_q   <= 1'b0;
            last_q     <= 1'b1;
            rsp_id_q   <= 1'b0;
            rsp_eq_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (gnt0) begin
                cmd_q    <= req0_cmd;
                gnt_id_q <= 1'b0;
            end else if (gnt1) begin
                cmd_q    <= req1_cmd;
                gnt_id_q <= 1'b1;
            end
            if (state == COMMIT) begin
                rsp_data_q <= bus.dp_aluout;
                rsp_eq_q   <= bus.dp_eq;
                rsp_id_q   <= gnt_id_q;
                last_q     <= gnt_id_q;
            end
        end
    end

    // Datapath control is decoded from state so it drops with reset immediately.
    always_comb begin
        bus.dp_rs1      = '0;
        bus.dp_rs2      = '0;
        bus.dp_rd       = '0;
        bus.dp_imm      = '0;
        bus.dp_alusrc   = 1'b0;
        bus.dp_aluctrl  = 1'b0;
        bus.dp_regwrite = 1'b0;
        if (state == EXEC || state == COMMIT) begin
            bus.dp_rs1     = cmd_q.rs1;
            bus.dp_rs2     = cmd_q.rs2;
            bus.dp_rd      = cmd_q.rd;
            bus.dp_imm     = cmd_q.imm;
            bus.dp_alusrc  = cmd_q.alusrc;
            bus.dp_aluctrl = cmd_q.aluctrl;
        end
        if (state == COMMIT) begin
`ifdef X0_GUARD_EN
            bus.dp_regwrite = cmd_q.wr && (cmd_q.rd != '0);
`else
            bus.dp_regwrite = cmd_q.wr;
`endif
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_eq     = rsp_eq_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic, checked against
// an op-level reference (register array + arithmetic + round-robin rule).
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    alu_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic        aluctrl;
        logic        wr;
    } cmd_t;

    int total = 0;
    int bad   = 0;

    // Datapath environment: register file plus ALU (0 = add, 1 = subtract).
    logic [31:0] rf [32];
    logic [31:0] alu_b;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always_comb begin
        alu_b         = bus.dp_alusrc ? bus.dp_imm : rf[bus.dp_rs2];
        bus.dp_aluout = bus.dp_aluctrl ? rf[bus.dp_rs1] - alu_b : rf[bus.dp_rs1] + alu_b;
        bus.dp_eq     = (rf[bus.dp_rs1] == alu_b);
    end

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (bus.dp_regwrite) rf[bus.dp_rd] <= bus.dp_aluout;
    end

    // Reference state at operation level.
    logic [31:0] ref_rf [32];
    logic        m_last = 1'b1;

    function automatic logic [31:0] ref_b(input cmd_t c);
        return c.alusrc ? c.imm : ref_rf[c.rs2];
    endfunction

    function automatic logic [31:0] ref_alu(input cmd_t c);
        return c.aluctrl ? ref_rf[c.rs1] - ref_b(c) : ref_rf[c.rs1] + ref_b(c);
    endfunction

    function automatic logic ref_eq(input cmd_t c);
        return ref_rf[c.rs1] == ref_b(c);
    endfunction

    function automatic logic ref_we(input cmd_t c);
`ifdef X0_GUARD_EN
        return c.wr && (c.rd != 5'd0);
`else
        return c.wr;
`endif
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.rs1     = 5'($urandom_range(0, 31));
        c.rs2     = 5'($urandom_range(0, 31));
        c.rd      = 5'($urandom_range(0, 31));
        c.imm     = $urandom;
        c.alusrc  = 1'($urandom_range(0, 1));
        c.aluctrl = 1'($urandom_range(0, 1));
        c.wr      = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input int id, input logic v, input cmd_t c);
        if (id == 0) begin
            bus.req0_valid = v;  bus.req0_rs1 = c.rs1; bus.req0_rs2 = c.rs2;
            bus.req0_rd = c.rd;  bus.req0_imm = c.imm; bus.req0_alusrc = c.alusrc;
            bus.req0_aluctrl = c.aluctrl; bus.req0_wr = c.wr;
        end else begin
            bus.req1_valid = v;  bus.req1_rs1 = c.rs1; bus.req1_rs2 = c.rs2;
            bus.req1_rd = c.rd;  bus.req1_imm = c.imm; bus.req1_alusrc = c.alusrc;
            bus.req1_aluctrl = c.aluctrl; bus.req1_wr = c.wr;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) begin
            pl_en   = 1'b1;
            pl_addr = 5'(i);
            pl_data = (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : $urandom;
            ref_rf[i] = pl_data;
            tick();
        end
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy,
             bus.dp_alusrc, bus.dp_aluctrl, bus.dp_regwrite} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {bus.req0_ready, bus.req1_ready, bus.rsp_valid,
                     bus.rsp_id, bus.rsp_eq, bus.busy, bus.dp_alusrc, bus.dp_aluctrl, bus.dp_regwrite});
        end
        total++;
        if ({bus.rsp_data, bus.dp_imm, bus.dp_rs1, bus.dp_rs2, bus.dp_rd} !== 79'b0) begin
            bad++;
            $display("FAIL reset_data got data=%h imm=%h rs1=%h rs2=%h rd=%h exp=0",
                     bus.rsp_data, bus.dp_imm, bus.dp_rs1, bus.dp_rs2, bus.dp_rd);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        #1;
        total++;
        if ({bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 4'b0) begin
            bad++;
            $display("FAIL reset_release got=%b exp=0000",
                     {bus.busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready});
        end
        m_last = 1'b1;
    endtask

    task automatic test_single_op();
        cmd_t c;
        c = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd3, imm: 32'd0, alusrc: 1'b0, aluctrl: 1'b0, wr: 1'b1};
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive_req(0, 1'b1, c);
        #1;
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            bad++;
            $display("FAIL single_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        drive_req(0, 1'b0, c);
        #1;
        total++;
        if ({bus.req0_ready, bus.busy, bus.dp_regwrite, bus.dp_rs1, bus.dp_rs2, bus.dp_rd} !==
            {1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3}) begin
            bad++;
            $display("FAIL single_exec got rdy=%b busy=%b we=%b rs1=%0d rs2=%0d rd=%0d", bus.req0_ready,
                     bus.busy, bus.dp_regwrite, bus.dp_rs1, bus.dp_rs2, bus.dp_rd);
        end
        tick();
        #1;
        total++;
        if ({bus.dp_regwrite, bus.rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL single_commit got we,vld=%b exp=10", {bus.dp_regwrite, bus.rsp_valid});
        end
        tick();
        #1;
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.dp_regwrite} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
            bad++;
            $display("FAIL single_rsp got vld=%b id=%b data=%0d we=%b exp 1 0 12 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.dp_regwrite);
        end
        total++;
        if (rf[3] !== 32'd12) begin
            bad++;
            $display("FAIL single_wb got x3=%0d exp=12", rf[3]);
        end
        ref_rf[3] = 32'd12;
        m_last = 1'b0;
        tick();
        #1;
        total++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL single_idle got=%b exp=00", {bus.rsp_valid, bus.busy});
        end
    endtask

    task automatic test_immediate();
        cmd_t c;
        bit seen_we;
        bit ok;
        int diff;
        logic [31:0] ed;
        c = '{rs1: 5'd3, rs2: 5'd9, rd: 5'd5, imm: 32'hFFFF_FFFF, alusrc: 1'b1, aluctrl: 1'b0, wr: 1'b0};
        ed = ref_alu(c);
        @(negedge clk);
        drive_req(1, 1'b1, c);
        #1;
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            bad++;
            $display("FAIL imm_grant got=%b exp=10", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        drive_req(1, 1'b0, c);
        seen_we = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (bus.dp_regwrite) seen_we = 1'b1;
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!ok || seen_we || bus.rsp_id !== 1'b1 || bus.rsp_data !== ed) begin
            bad++;
            $display("FAIL imm_rsp got ok=%b we=%b id=%b data=%h exp 1 0 1 %h",
                     ok, seen_we, bus.rsp_id, bus.rsp_data, ed);
        end
        diff = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) diff++;
        total++;
        if (diff != 0) begin
            bad++;
            $display("FAIL imm_rf got %0d changed regs exp=0", diff);
        end
        m_last = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        cmd_t c;
        cmd_t c2;
        bit ok;
        logic [31:0] ed;
        c = rand_cmd();
        c.wr = 1'b0;
        ed = ref_alu(c);
        bus.rsp_ready = 1'b0;
        drive_req(0, 1'b1, c);
        tick();
        drive_req(0, 1'b0, c);
        wait_rsp(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_wait got no rsp_valid exp=1");
        end
        c2 = rand_cmd();
        c2.wr = 1'b0;
        drive_req(0, 1'b1, c2);
        for (int n = 0; n < 10; n++) begin
            #1;
            total++;
            if ({bus.rsp_valid, bus.rsp_data, bus.req0_ready, bus.req1_ready, bus.busy} !==
                {1'b1, ed, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold n=%0d got vld=%b data=%h rdy0=%b busy=%b exp 1 %h 0 1",
                         n, bus.rsp_valid, bus.rsp_data, bus.req0_ready, bus.busy, ed);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        total++;
        if ({bus.req0_ready, bus.rsp_valid, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL stall_regrant got rdy,vld,busy=%b exp=100",
                     {bus.req0_ready, bus.rsp_valid, bus.busy});
        end
        ed = ref_alu(c2);
        tick();
        drive_req(0, 1'b0, c2);
        wait_rsp(ok);
        total++;
        if (!ok || bus.rsp_data !== ed || bus.rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL stall_second got ok=%b data=%h id=%b exp 1 %h 0", ok, bus.rsp_data, bus.rsp_id, ed);
        end
        m_last = 1'b0;
        tick();
    endtask

    task automatic test_x0_guard();
        cmd_t c;
        logic [31:0] ed;
        c = rand_cmd();
        c.rd = 5'd0;
        c.wr = 1'b1;
        ed = ref_alu(c);
        drive_req(0, 1'b1, c);
        tick();
        drive_req(0, 1'b0, c);
        tick();
        #1;
        total++;
        if ({bus.dp_regwrite, bus.dp_rd} !== {ref_we(c), 5'd0}) begin
            bad++;
            $display("FAIL x0_we got we=%b rd=%0d exp %b 0", bus.dp_regwrite, bus.dp_rd, ref_we(c));
        end
        tick();
        #1;
        total++;
        if (bus.rsp_data !== ed || bus.rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL x0_rsp got vld=%b data=%h exp 1 %h", bus.rsp_valid, bus.rsp_data, ed);
        end
        if (ref_we(c)) ref_rf[0] = ed;
        total++;
        if (rf[0] !== ref_rf[0]) begin
            bad++;
            $display("FAIL x0_reg got=%h exp=%h", rf[0], ref_rf[0]);
        end
        m_last = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        cmd_t c1;
        bit ok;
        c = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd4, imm: 32'd0, alusrc: 1'b0, aluctrl: 1'b1, wr: 1'b1};
        drive_req(0, 1'b1, c);
        tick();
        drive_req(0, 1'b0, c);
        tick();
        #1;
        total++;
        if (bus.dp_regwrite !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_commit got we=%b exp=1", bus.dp_regwrite);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.dp_regwrite, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data,
             bus.dp_rs1, bus.dp_rs2, bus.dp_rd, bus.dp_imm, bus.dp_alusrc, bus.dp_aluctrl} !== 86'b0) begin
            bad++;
            $display("FAIL rstmid_outputs got we=%b busy=%b vld=%b data=%h rd=%0d exp all 0",
                     bus.dp_regwrite, bus.busy, bus.rsp_valid, bus.rsp_data, bus.dp_rd);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        #1;
        total++;
        if (rf[4] !== ref_rf[4]) begin
            bad++;
            $display("FAIL rstmid_reg got x4=%h exp=%h", rf[4], ref_rf[4]);
        end
        c = rand_cmd();
        c.wr = 1'b0;
        c1 = rand_cmd();
        c1.wr = 1'b0;
        drive_req(0, 1'b1, c);
        drive_req(1, 1'b1, c1);
        #1;
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rstmid_prio got=%b exp=01", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        drive_req(0, 1'b0, c);
        drive_req(1, 1'b0, c1);
        wait_rsp(ok);
        total++;
        if (!ok || bus.rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_rsp got ok=%b id=%b exp 1 0", ok, bus.rsp_id);
        end
        m_last = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        cmd_t c0;
        cmd_t c1;
        logic [1:0] g;
        logic exp_id;
        logic q[$];
        int grants;
        c0 = rand_cmd(); c0.wr = 1'b0;
        c1 = rand_cmd(); c1.wr = 1'b0;
        exp_id = !m_last;
        grants = 0;
        bus.rsp_ready = 1'b1;
        drive_req(0, 1'b1, c0);
        drive_req(1, 1'b1, c1);
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc == 40) begin
                drive_req(0, 1'b0, c0);
                drive_req(1, 1'b0, c1);
            end
            #1;
            g = {bus.req1_ready, bus.req0_ready};
            if (g != 2'b00) begin
                total++;
                if (g !== (exp_id ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL b2b_grant cyc=%0d got=%b exp_id=%b", cyc, g, exp_id);
                end
                q.push_back(exp_id);
                m_last = exp_id;
                exp_id = !exp_id;
                grants++;
            end
            if (bus.rsp_valid) begin
                total++;
                if (q.size() == 0 || bus.rsp_id !== q[0]) begin
                    bad++;
                    $display("FAIL b2b_rsp_id cyc=%0d got=%b", cyc, bus.rsp_id);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            tick();
        end
        total++;
        if (grants != 10 || q.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got grants=%0d left=%0d busy=%b exp 10 0 0", grants, q.size(), bus.busy);
        end
    endtask

    task automatic test_random();
        cmd_t pc[2];
        bit ph[2];
        cmd_t gc;
        int since;
        int gid;
        int eg;
        int cyc;
        int diff;
        bit gen;
        logic [31:0] ed;
        logic ee;
        ph[0] = 1'b0; ph[1] = 1'b0;
        pc[0] = '0;   pc[1] = '0;
        gc = '0; since = -1; gid = 0; eg = -1; cyc = 0; ed = '0; ee = 1'b0;
        while (cyc < 800) begin
            gen = (cyc < 300);
            if (!gen && !ph[0] && !ph[1] && since < 0) break;
            for (int i = 0; i < 2; i++) begin
                if (!ph[i]) begin
                    if (gen && $urandom_range(0, 2) == 0) begin
                        pc[i] = rand_cmd();
                        ph[i] = 1'b1;
                        drive_req(i, 1'b1, pc[i]);
                    end else begin
                        drive_req(i, 1'b0, pc[i]);
                    end
                end
            end
            bus.rsp_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (since < 0) begin
                eg = -1;
                if (ph[0] && ph[1]) eg = m_last ? 0 : 1;
                else if (ph[0])     eg = 0;
                else if (ph[1])     eg = 1;
                total++;
                if ({bus.req1_ready, bus.req0_ready, bus.busy, bus.rsp_valid, bus.dp_regwrite} !==
                    {eg == 1, eg == 0, 3'b000}) begin
                    bad++;
                    $display("FAIL rnd_idle cyc=%0d got r1,r0,busy,vld,we=%b exp grant=%0d", cyc,
                             {bus.req1_ready, bus.req0_ready, bus.busy, bus.rsp_valid, bus.dp_regwrite}, eg);
                end
                if (eg >= 0) begin
                    gc = pc[eg];
                    gid = eg;
                    ed = ref_alu(gc);
                    ee = ref_eq(gc);
                    m_last = (eg == 1);
                    ph[eg] = 1'b0;
                end
            end else if (since < 3) begin
                total++;
                if ({bus.req1_ready, bus.req0_ready, bus.busy, bus.rsp_valid, bus.dp_rs1, bus.dp_rs2,
                     bus.dp_rd, bus.dp_imm, bus.dp_alusrc, bus.dp_aluctrl, bus.dp_regwrite} !==
                    {2'b00, 1'b1, 1'b0, gc.rs1, gc.rs2, gc.rd, gc.imm, gc.alusrc, gc.aluctrl,
                     (since == 2) && ref_we(gc)}) begin
                    bad++;
                    $display("FAIL rnd_dp cyc=%0d step=%0d got rs1=%0d rs2=%0d rd=%0d imm=%h we=%b exp %0d %0d %0d %h %b",
                             cyc, since, bus.dp_rs1, bus.dp_rs2, bus.dp_rd, bus.dp_imm, bus.dp_regwrite,
                             gc.rs1, gc.rs2, gc.rd, gc.imm, (since == 2) && ref_we(gc));
                end
            end else begin
                total++;
                if ({bus.req1_ready, bus.req0_ready, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_data,
                     bus.rsp_eq, bus.dp_regwrite} !== {2'b00, 1'b1, 1'b1, gid == 1, ed, ee, 1'b0}) begin
                    bad++;
                    $display("FAIL rnd_rsp cyc=%0d got vld=%b id=%b data=%h eq=%b exp 1 %0d %h %b",
                             cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_eq, gid, ed, ee);
                end
            end
            if (since < 0) begin
                since = (eg >= 0) ? 1 : -1;
            end else if (since == 1) begin
                since = 2;
            end else if (since == 2) begin
                if (ref_we(gc)) ref_rf[gc.rd] = ed;
                since = 3;
            end else if (bus.rsp_ready) begin
                since = -1;
            end
            tick();
            cyc++;
        end
        total++;
        if (cyc >= 800) begin
            bad++;
            $display("FAIL rnd_drain got no idle after %0d cycles", cyc);
        end
        diff = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== ref_rf[i]) diff++;
        total++;
        if (diff != 0) begin
            bad++;
            $display("FAIL rnd_rf got %0d mismatching regs exp=0", diff);
        end
    endtask

    initial begin
        drive_req(0, 1'b0, '0);
        drive_req(1, 1'b0, '0);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        preload();
        test_reset();
        test_single_op();
        test_immediate();
        test_stall();
        test_x0_guard();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp=finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
